// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: pixel-strobe divider, horizontal/vertical scan counters, sync
// and display-window decode, plus a per-frame motion FSM that moves the logo and
// reflects it off the display edges.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   run       1 = logo advances once per frame, 0 = position frozen
//   pix_en    one-clk strobe every CLK_DIV clks
//   h_count   horizontal scan position, 0..H_TOTAL-1
//   v_count   vertical scan position, 0..V_TOTAL-1
//   hsync     active-low horizontal sync
//   vsync     active-low vertical sync
//   video_on  inside the visible display window
//   frame_end one-clk pulse on the last pixel of a frame
//   logo_x/y  logo top-left corner
//   dir_x/y   0 = right/down, 1 = left/up
//   bounce_x/y one-clk pulse when that axis reflects
module vga_scan_ctrl #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned LOGO_W    = 64,
    parameter int unsigned LOGO_H    = 32,
    parameter int unsigned STEP      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic       pix_en,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_end,
    output logic [9:0] logo_x,
    output logic [9:0] logo_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       bounce_x,
    output logic       bounce_y
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);

    // 11-bit operands so logo + size + step cannot wrap before the edge compare
    localparam logic [10:0] X_LIM  = 11'(H_DISPLAY);
    localparam logic [10:0] Y_LIM  = 11'(V_DISPLAY);
    localparam logic [10:0] X_SPAN = 11'(LOGO_W + STEP);
    localparam logic [10:0] Y_SPAN = 11'(LOGO_H + STEP);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [9:0]  X_MAX  = 10'(H_DISPLAY - LOGO_W);
    localparam logic [9:0]  Y_MAX  = 10'(V_DISPLAY - LOGO_H);
    localparam logic [9:0]  STEP_P = 10'(STEP);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {StIdle = 2'd0, StUpdX = 2'd1, StUpdY = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic [9:0]       logo_x_d, logo_y_d;
    logic             dir_x_d, dir_y_d, bounce_x_d, bounce_y_d;
    logic [10:0]      x_w, y_w;
    logic             h_end, v_end;

    assign h_end = (h_count == H_LAST);
    assign v_end = (v_count == V_LAST);

    assign frame_end = pix_en & h_end & v_end;
    assign hsync     = !((h_count >= HS_START) && (h_count < HS_END));
    assign vsync     = !((v_count >= VS_START) && (v_count < VS_END));
    assign video_on  = (h_count < H_VIS) && (v_count < V_VIS);

    assign x_w = {1'b0, logo_x};
    assign y_w = {1'b0, logo_y};

    // Divider and scan counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            pix_en  <= 1'b0;
            h_count <= '0;
            v_count <= '0;
        end else begin
            pix_en <= (div_q == DIV_LAST);
            div_q  <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            if (pix_en) begin
                if (h_end) begin
                    h_count <= '0;
                    v_count <= v_end ? '0 : v_count + 10'd1;
                end else begin
                    h_count <= h_count + 10'd1;
                end
            end
        end
    end

    // The x step is committed on the edge into StUpdX and the y step on the edge
    // into StUpdY, so each axis's new position and bounce pulse are visible in
    // the matching state cycle.
    always_comb begin
        state_d    = state_q;
        logo_x_d   = logo_x;
        logo_y_d   = logo_y;
        dir_x_d    = dir_x;
        dir_y_d    = dir_y;
        bounce_x_d = 1'b0;
        bounce_y_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_end && run) begin
                    state_d = StUpdX;
                    if (!dir_x) begin
                        if (x_w + X_SPAN > X_LIM) begin
                            logo_x_d   = X_MAX;
                            dir_x_d    = 1'b1;
                            bounce_x_d = 1'b1;
                        end else begin
                            logo_x_d = logo_x + STEP_P;
                        end
                    end else if (x_w < STEP_W) begin
                        logo_x_d   = '0;
                        dir_x_d    = 1'b0;
                        bounce_x_d = 1'b1;
                    end else begin
                        logo_x_d = logo_x - STEP_P;
                    end
                end
            end
            StUpdX: begin
                state_d = StUpdY;
                if (!dir_y) begin
                    if (y_w + Y_SPAN > Y_LIM) begin
                        logo_y_d   = Y_MAX;
                        dir_y_d    = 1'b1;
                        bounce_y_d = 1'b1;
                    end else begin
                        logo_y_d = logo_y + STEP_P;
                    end
                end else if (y_w < STEP_W) begin
                    logo_y_d   = '0;
                    dir_y_d    = 1'b0;
                    bounce_y_d = 1'b1;
                end else begin
                    logo_y_d = logo_y - STEP_P;
                end
            end
            StUpdY: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            logo_x   <= '0;
            logo_y   <= '0;
            dir_x    <= 1'b0;
            dir_y    <= 1'b0;
            bounce_x <= 1'b0;
            bounce_y <= 1'b0;
        end else begin
            state_q  <= state_d;
            logo_x   <= logo_x_d;
            logo_y   <= logo_y_d;
            dir_x    <= dir_x_d;
            dir_y    <= dir_y_d;
            bounce_x <= bounce_x_d;
            bounce_y <= bounce_y_d;
        end
    end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl using a reduced timing set so whole frames are short:
// H 20/2/3/2 (27 total, hsync low 22..24), V 20/1/2/1 (24 total, vsync low
// 21..22), CLK_DIV 2 (frame = 1296 clks), logo 8x8, step 3.
module tb_vga_scan_ctrl;

    localparam int unsigned FRAME_CLKS = 27 * 24 * 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       pix_en, hsync, vsync, video_on, frame_end;
    logic [9:0] h_count, v_count, logo_x, logo_y;
    logic       dir_x, dir_y, bounce_x, bounce_y;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       dx;
        logic       dy;
        logic       bx;
        logic       by;
    } exp_t;

    exp_t sb[$];

    vga_scan_ctrl #(
        .H_DISPLAY(20), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(20), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .CLK_DIV(2), .LOGO_W(8), .LOGO_H(8), .STEP(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .pix_en(pix_en), .h_count(h_count), .v_count(v_count),
        .hsync(hsync), .vsync(vsync), .video_on(video_on), .frame_end(frame_end),
        .logo_x(logo_x), .logo_y(logo_y), .dir_x(dir_x), .dir_y(dir_y),
        .bounce_x(bounce_x), .bounce_y(bounce_y)
    );

    always #5 clk = ~clk;

    // Returns at the negedge where frame_end is observed high.
    task automatic wait_frame_end(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < FRAME_CLKS + 100; i++) begin
            @(negedge clk);
            if (frame_end === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL frame_end_timeout: got no pulse, required one within %0d clks",
                     FRAME_CLKS + 100);
        end
    endtask

    task automatic test_reset();
        run = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({pix_en, h_count, v_count, hsync, vsync, video_on, frame_end} !==
            {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_scan: pix_en=%b h=%0d v=%0d hs=%b vs=%b von=%b fe=%b, required 0 0 0 1 1 1 0",
                     pix_en, h_count, v_count, hsync, vsync, video_on, frame_end);
        end
        checks++;
        if ({logo_x, logo_y, dir_x, dir_y, bounce_x, bounce_y} !== 24'd0) begin
            failures++;
            $display("FAIL reset_logo: x=%0d y=%0d dx=%b dy=%b bx=%b by=%b, required all 0",
                     logo_x, logo_y, dir_x, dir_y, bounce_x, bounce_y);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pix_en !== 1'b0) begin
            failures++;
            $display("FAIL first_clk_pix_en: got %b, required 0", pix_en);
        end
        @(negedge clk);
        checks++;
        if (pix_en !== 1'b1 || h_count !== 10'd0) begin
            failures++;
            $display("FAIL second_clk_pix_en: pix_en=%b h=%0d, required 1 and 0", pix_en, h_count);
        end
        @(negedge clk);
        checks++;
        if (pix_en !== 1'b0 || h_count !== 10'd1) begin
            failures++;
            $display("FAIL first_h_step: pix_en=%b h=%0d, required 0 and 1", pix_en, h_count);
        end
    endtask

    // Runs one full frame against a bench-side counter model.
    task automatic test_timing();
        bit ok;
        int hm, vm, err_cnt, err_hs, err_vs, err_von, err_pen, err_fe, hs_low, vs_lines;
        bit pen, fe_exp;
        wait_frame_end(ok);
        if (!ok) return;
        hm = 0; vm = 0;
        err_cnt = 0; err_hs = 0; err_vs = 0; err_von = 0; err_pen = 0; err_fe = 0;
        hs_low = 0; vs_lines = 0;
        for (int i = 1; i <= int'(FRAME_CLKS); i++) begin
            @(negedge clk);
            pen = (i % 2 == 0);
            fe_exp = pen && hm == 26 && vm == 23;
            if (h_count !== 10'(hm) || v_count !== 10'(vm)) err_cnt++;
            if (hsync !== !(hm >= 22 && hm < 25)) err_hs++;
            if (vsync !== !(vm >= 21 && vm < 23)) err_vs++;
            if (video_on !== (hm < 20 && vm < 20)) err_von++;
            if (pix_en !== pen) err_pen++;
            if (frame_end !== fe_exp) err_fe++;
            if (pen && vm == 0 && hsync === 1'b0) hs_low++;
            if (pen && hm == 0 && vsync === 1'b0) vs_lines++;
            if (pen) begin
                if (hm == 26) begin
                    hm = 0;
                    vm = (vm == 23) ? 0 : vm + 1;
                end else begin
                    hm++;
                end
            end
        end
        checks++;
        if (err_cnt != 0) begin failures++; $display("FAIL counters: %0d bad clks, required 0", err_cnt); end
        checks++;
        if (err_hs != 0) begin failures++; $display("FAIL hsync_decode: %0d bad clks, required 0", err_hs); end
        checks++;
        if (err_vs != 0) begin failures++; $display("FAIL vsync_decode: %0d bad clks, required 0", err_vs); end
        checks++;
        if (err_von != 0) begin failures++; $display("FAIL video_on: %0d bad clks, required 0", err_von); end
        checks++;
        if (err_pen != 0) begin failures++; $display("FAIL pix_en_period: %0d bad clks, required 0", err_pen); end
        checks++;
        if (err_fe != 0) begin failures++; $display("FAIL frame_end_period: %0d bad clks, required 0", err_fe); end
        checks++;
        if (hs_low != 3) begin failures++; $display("FAIL hsync_width: got %0d pixels, required 3", hs_low); end
        checks++;
        if (vs_lines != 2) begin failures++; $display("FAIL vsync_lines: got %0d lines, required 2", vs_lines); end
        @(negedge clk);
        checks++;
        if (frame_end !== 1'b0 || h_count !== 10'd0 || v_count !== 10'd0) begin
            failures++;
            $display("FAIL frame_wrap: fe=%b h=%0d v=%0d, required 0 0 0", frame_end, h_count, v_count);
        end
    endtask

    // Both axes share geometry, so every bounce is a corner hit.
    task automatic test_bounce();
        logic [9:0] pos_tab [10] = '{10'd3, 10'd6, 10'd9, 10'd12, 10'd12,
                                     10'd9, 10'd6, 10'd3, 10'd0, 10'd0};
        logic       dir_tab [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
        logic       bnc_tab [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        exp_t e;
        bit ok;
        run = 1'b1;
        for (int f = 0; f < 10; f++) begin
            wait_frame_end(ok);
            if (!ok) break;
            sb.push_back('{x: pos_tab[f], y: pos_tab[f], dx: dir_tab[f], dy: dir_tab[f],
                           bx: bnc_tab[f], by: bnc_tab[f]});
            @(negedge clk);
            e = sb[0];
            checks++;
            if (logo_x !== e.x || dir_x !== e.dx || bounce_x !== e.bx || bounce_y !== 1'b0) begin
                failures++;
                $display("FAIL bounce_x_upd%0d: x=%0d dx=%b bx=%b by=%b, required %0d %b %b 0",
                         f, logo_x, dir_x, bounce_x, bounce_y, e.x, e.dx, e.bx);
            end
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (logo_y !== e.y || dir_y !== e.dy || bounce_y !== e.by || bounce_x !== 1'b0) begin
                failures++;
                $display("FAIL bounce_y_upd%0d: y=%0d dy=%b by=%b bx=%b, required %0d %b %b 0",
                         f, logo_y, dir_y, bounce_y, bounce_x, e.y, e.dy, e.by);
            end
        end
        run = 1'b0;
    endtask

    task automatic test_freeze();
        bit ok;
        run = 1'b0;
        for (int f = 0; f < 3; f++) begin
            wait_frame_end(ok);
            if (!ok) break;
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (logo_x !== 10'd0 || logo_y !== 10'd0 || bounce_x !== 1'b0 ||
                bounce_y !== 1'b0 || dut.state_q !== 2'd0) begin
                failures++;
                $display("FAIL freeze%0d: x=%0d y=%0d bx=%b by=%b st=%0d, required 0 0 0 0 0",
                         f, logo_x, logo_y, bounce_x, bounce_y, dut.state_q);
            end
        end
    endtask

    task automatic test_run_drop();
        exp_t e;
        bit ok;
        run = 1'b1;
        wait_frame_end(ok);
        if (!ok) return;
        sb.push_back('{x: 10'd3, y: 10'd3, dx: 1'b0, dy: 1'b0, bx: 1'b0, by: 1'b0});
        @(negedge clk);
        run = 1'b0;
        checks++;
        if (logo_x !== sb[0].x) begin
            failures++;
            $display("FAIL run_drop_x: x=%0d, required %0d", logo_x, sb[0].x);
        end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (logo_y !== e.y || dir_y !== e.dy) begin
            failures++;
            $display("FAIL run_drop_y: y=%0d dy=%b, required %0d %b", logo_y, dir_y, e.y, e.dy);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        run = 1'b1;
        wait_frame_end(ok);
        if (!ok) return;
        @(negedge clk);
        checks++;
        if (logo_x !== 10'd6 || logo_y !== 10'd3) begin
            failures++;
            $display("FAIL pre_reset_upd_x: x=%0d y=%0d, required 6 3", logo_x, logo_y);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (logo_x !== 10'd0 || logo_y !== 10'd0 || h_count !== 10'd0 || v_count !== 10'd0 ||
            dut.state_q !== 2'd0 || pix_en !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: x=%0d y=%0d h=%0d v=%0d st=%0d pen=%b, required all 0",
                     logo_x, logo_y, h_count, v_count, dut.state_q, pix_en);
        end
        run = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bounce_x !== 1'b0 || bounce_y !== 1'b0 || logo_y !== 10'd0 || logo_x !== 10'd0) begin
                failures++;
                $display("FAIL post_reset%0d: bx=%b by=%b x=%0d y=%0d, required 0 0 0 0",
                         i, bounce_x, bounce_y, logo_x, logo_y);
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_bounce();
        test_freeze();
        test_run_drop();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
